// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver, the receive-side partner of the existing
// transmitter. It sits between the board RX pin and the CPU UART peripheral.
//
// The asynchronous serial line passes through a two-flop synchronizer. The
// receiver samples each bit near its middle. A start bit that is no longer low
// at its midpoint counts as a glitch and is ignored.
//
// Ports:
//   clock_baud_x16  in   sampling clock running at OVERSAMPLE x baud
//   reset_n         in   asynchronous, active-low reset
//   serial_rx       in   asynchronous serial line, idles high
//   rx_data         out  last correctly framed byte, held until the next one
//   rx_valid        out  one-cycle pulse when rx_data is updated
//   rx_busy         out  high whenever a frame is in progress (state != IDLE)
//   frame_err       out  one-cycle pulse when a stop bit is sampled low
//
// Parameter:
//   OVERSAMPLE      clock cycles per bit period (even, >= 4)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock_baud_x16,
    input  logic       reset_n,
    input  logic       serial_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic             sync1;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // The synchronizer flops reset to the idle-high level. A reset therefore
    // cannot look like a start bit.
    always_ff @(posedge clock_baud_x16 or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= serial_rx;
            rx_s  <= sync1;
        end
    end

    // Frame state machine. START waits half a bit, so that every later sample
    // lands in the middle of its bit. DATA and STOP then each wait one full bit
    // period per sample.
    always_ff @(posedge clock_baud_x16 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        // If the line is high again at mid start bit, the low
                        // level was only a glitch.
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        // Data arrives LSB first, so each new bit enters at
                        // the top of the register and shifts down.
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    // A break (line held low) must not start a new frame
                    // again and again. Wait here until the line goes high.
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- scoreboard testbench for uart_rx.
//
// The stimulus process drives serial frames. It works out the response each
// frame should produce (good byte or framing error, plus the rx_data value
// expected at that moment) and pushes it onto a queue. A separate monitor pops
// that queue whenever the receiver pulses rx_valid or frame_err.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT = 16;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       serial_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    exp_t       exp_q[$];
    int         check_count = 0;
    int         fail_count  = 0;
    int         busy_cycles = 0;
    logic [7:0] last_good   = 8'h00;

    uart_rx #(.OVERSAMPLE(BIT)) dut (
        .clock_baud_x16 (clk),
        .reset_n        (reset_n),
        .serial_rx      (serial_rx),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_busy        (rx_busy),
        .frame_err      (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and keep count.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one 8N1 frame. The scoreboard entry comes from the frame contents:
    // a high stop bit delivers the byte, a low stop bit is a framing error
    // that leaves the previous byte in place. Each internal bit edge moves by
    // a random offset of up to +/-jmax clocks. The frame itself always lasts
    // exactly 10 bit periods.
    task automatic apply_stimulus(input logic [7:0] data, input bit stop_ok,
                                  input int jmax);
        logic [9:0] levels;
        int         edges[11];
        exp_t       e;
        levels = {stop_ok, data, 1'b0};
        edges[0]  = 0;
        edges[10] = 10 * BIT;
        for (int i = 1; i < 10; i++) begin
            edges[i] = i * BIT + int'($urandom_range(2 * jmax, 0)) - jmax;
        end
        if (stop_ok) begin
            e.is_err  = 1'b0;
            e.data    = data;
            last_good = data;
        end else begin
            e.is_err = 1'b1;
            e.data   = last_good;
        end
        exp_q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            serial_rx = levels[i];
            repeat (edges[i+1] - edges[i]) @(negedge clk);
        end
    endtask

    task automatic drive_line(input logic level, input int cycles);
        serial_rx = level;
        repeat (cycles) @(negedge clk);
    endtask

    // Wait a bounded number of cycles for rx_busy to drop. The final check
    // fails if the bound runs out first.
    task automatic wait_busy_low(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!rx_busy) break;
            @(negedge clk);
        end
        check_output(name, 32'(rx_busy), 32'd0);
    endtask

    task automatic apply_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) @(negedge clk);
        reset_n   = 1'b1;
        last_good = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: count busy cycles and score every output pulse against the
    // oldest pending expectation.
    always @(negedge clk) begin
        if (rx_busy) busy_cycles <= busy_cycles + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (rx_valid || frame_err)) begin
            check_output("valid_err_exclusive", 32'(rx_valid & frame_err), 32'd0);
            if (exp_q.size() == 0) begin
                check_output("unexpected_output", 32'({rx_valid, frame_err}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("event_kind", 32'(frame_err), 32'(e.is_err));
                check_output("rx_data", 32'(rx_data), 32'(e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         busy_start;
        logic [7:0] partial;
        logic [7:0] rnd;
        bit         ok;

        // Reset held while the line toggles: every output stays at its reset value.
        reset_n   = 1'b0;
        serial_rx = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            serial_rx = ~serial_rx;
            check_output("reset_outputs", 32'({rx_data, rx_valid, rx_busy, frame_err}), 32'd0);
        end
        serial_rx = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_output("idle_after_reset", 32'(rx_busy), 32'd0);

        // Single byte at the exact bit rate. rx_busy spans start, 8 data bits and stop.
        $display("[TB] single byte A5");
        busy_start = busy_cycles;
        apply_stimulus(8'hA5, 1'b1, 0);
        drive_line(1'b1, 12);
        check_output("busy_cycles_a5", 32'(busy_cycles - busy_start), 32'd152);
        check_output("rx_data_held_a5", 32'(rx_data), 32'hA5);

        // Back-to-back frames with bit-edge jitter.
        $display("[TB] back-to-back with jitter");
        apply_stimulus(8'h00, 1'b1, 3);
        apply_stimulus(8'hFF, 1'b1, 3);
        apply_stimulus(8'h3C, 1'b1, 3);
        drive_line(1'b1, 20);

        // Short low glitch: the receiver leaves IDLE, then rejects it.
        $display("[TB] start-bit glitch");
        drive_line(1'b0, 4);
        check_output("glitch_busy_seen", 32'(rx_busy), 32'd1);
        drive_line(1'b0, 1);
        serial_rx = 1'b1;
        wait_busy_low("glitch_busy_drop", 10);
        drive_line(1'b1, 20);

        // Framing error followed by a break, then a good byte.
        $display("[TB] framing error and break");
        apply_reset(3);
        apply_stimulus(8'h55, 1'b0, 0);
        drive_line(1'b0, 40);
        check_output("break_holds_busy", 32'(rx_busy), 32'd1);
        serial_rx = 1'b1;
        wait_busy_low("break_release", 10);
        check_output("rx_data_after_ferr", 32'(rx_data), 32'h00);
        drive_line(1'b1, 16);
        apply_stimulus(8'h81, 1'b1, 0);
        drive_line(1'b1, 12);

        // Reset in the middle of bit 4 of C3 discards the partial byte.
        $display("[TB] reset mid-frame");
        partial = 8'hC3;
        drive_line(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_line(partial[i], BIT);
        drive_line(partial[4], BIT / 2);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("midframe_reset_busy", 32'(rx_busy), 32'd0);
        check_output("midframe_reset_data", 32'(rx_data), 32'h00);
        serial_rx = 1'b1;
        repeat (4) @(negedge clk);
        reset_n   = 1'b1;
        last_good = 8'h00;
        drive_line(1'b1, 20);
        apply_stimulus(8'h7E, 1'b1, 0);
        drive_line(1'b1, 12);

        // Random bytes, jitter, gaps and the occasional bad stop bit. After a
        // bad stop the line must return high before the next start bit.
        $display("[TB] randomized frames");
        for (int n = 0; n < 24; n++) begin
            rnd = 8'($urandom_range(255, 0));
            ok  = ($urandom_range(9, 0) != 0);
            apply_stimulus(rnd, ok, int'($urandom_range(3, 0)));
            drive_line(1'b1, ok ? int'($urandom_range(8, 0)) : int'($urandom_range(8, 4)));
        end
        drive_line(1'b1, 20);

        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
